axi_burst_master: RTL and testbench

- AXI4 initiator for a simple local request port; the counterpart of the team's AXI-to-RAM responder. Lets a core or DMA engine issue single-beat or INCR bursts to any AXI slave in the fabric.
- Accepts one request (read or write, address, length, ID) at a time.
- Write data is pulled from a local stream onto W; read data is pushed from R onto a local stream.
- A completion pulse is raised when the B response or the last R beat is accepted.

---
 rtl/axi_burst_master.sv | 259 +++++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// ---------------------------------------------------------------------------
// axi_burst_master
//
// Purpose:
//   AXI4 initiator for a simple local request port. Accepts one request at
//   a time, issues one AW or AR burst (INCR, full-width beats). It moves
//   write data from a local stream onto W and read data from R onto a local
//   stream. It raises a one-cycle completion pulse after the B response or
//   the terminating R beat.
//
// Configuration:
//   AXI_BURST_MASTER_RCHECK_EN - when defined, read bursts are checked:
//     rlast position against the requested length, and every rid against
//     the request id. A mismatch is reported on done_err. A burst also
//     terminates on beat==len even without rlast. When undefined, done_err
//     is 0 and reads terminate on m_rlast only.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_*               request handshake and payload (write/addr/len/id)
//   wr_*                local write-data stream (sink side)
//   rd_*                local read-data stream (source side)
//   done_*              completion pulse, kind (1=write), error flag
//   m_aw*, m_w*, m_b*   AXI write address / data / response channels
//   m_ar*, m_r*         AXI read address / data channels
//   dbg_state_o         current FSM state encoding
//
// Handshake rule (all valid/ready pairs): a transfer happens on a rising
// clock edge where valid and ready are both 1; valid, once raised, is held
// with a stable payload until that transfer.
// ---------------------------------------------------------------------------
module axi_burst_master #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [7:0]              req_len,
    input  logic [ID_WIDTH-1:0]     req_id,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    done_valid,
    output logic                    done_write,
    output logic                    done_err,
    output logic [ID_WIDTH-1:0]     m_awid,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [ID_WIDTH-1:0]     m_bid,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ID_WIDTH-1:0]     m_arid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [ID_WIDTH-1:0]     m_rid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic [2:0]              dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WADDR = 3'd1,
        S_WDATA = 3'd2,
        S_WRESP = 3'd3,
        S_RADDR = 3'd4,
        S_RDATA = 3'd5
    } state_t;

    localparam logic [2:0] BEAT_SIZE = 3'($clog2(DATA_WIDTH / 8));

    state_t                  state_q, state_d;
    logic [7:0]              beat_q, beat_d;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic                    done_valid_q, done_write_q, done_err_q;

    logic req_fire, aw_fire, ar_fire, w_fire, b_fire, r_fire;
    logic last_beat, r_end, r_err;

    assign req_fire  = req_valid & req_ready;
    assign aw_fire   = (state_q == S_WADDR) & m_awready;
    assign ar_fire   = (state_q == S_RADDR) & m_arready;
    assign w_fire    = (state_q == S_WDATA) & wr_valid & m_wready;
    assign b_fire    = (state_q == S_WRESP) & m_bvalid;
    assign r_fire    = (state_q == S_RDATA) & m_rvalid & rd_ready;
    assign last_beat = (beat_q == len_q);

`ifdef AXI_BURST_MASTER_RCHECK_EN
    logic rid_err_q;
    logic rid_bad;
    logic unused_ok;

    assign rid_bad   = (m_rid != id_q);
    // Terminate on rlast or on the expected final beat, whichever comes first.
    assign r_end     = r_fire & (m_rlast | last_beat);
    // Error if rlast and the expected final beat disagree, or any rid was wrong.
    assign r_err     = rid_err_q | rid_bad | (m_rlast != last_beat);
    assign unused_ok = ^m_bid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rid_err_q <= 1'b0;
        end else if (ar_fire) begin
            rid_err_q <= 1'b0;
        end else if (r_fire && rid_bad) begin
            rid_err_q <= 1'b1;
        end
    end
`else
    logic unused_ok;

    assign r_end     = r_fire & m_rlast;
    assign r_err     = 1'b0;
    assign unused_ok = ^{m_bid, m_rid};
`endif

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beat_q       <= 8'd0;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= 8'd0;
            done_valid_q <= 1'b0;
            done_write_q <= 1'b0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            if (req_fire) begin
                id_q   <= req_id;
                addr_q <= req_addr;
                len_q  <= req_len;
            end
            done_valid_q <= b_fire | r_end;
            done_write_q <= b_fire;
            done_err_q   <= r_end & r_err;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_fire) state_d = req_write ? S_WADDR : S_RADDR;
            end
            S_WADDR: begin
                if (aw_fire) begin
                    state_d = S_WDATA;
                    beat_d  = 8'd0;
                end
            end
            S_WDATA: begin
                if (w_fire) begin
                    beat_d = beat_q + 8'd1;
                    if (last_beat) state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (b_fire) state_d = S_IDLE;
            end
            S_RADDR: begin
                if (ar_fire) begin
                    state_d = S_RDATA;
                    beat_d  = 8'd0;
                end
            end
            S_RDATA: begin
                if (r_fire) beat_d = beat_q + 8'd1;
                if (r_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = 1'b0;
        m_awvalid = 1'b0;
        m_arvalid = 1'b0;
        m_wvalid  = 1'b0;
        wr_ready  = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wlast   = 1'b0;
        m_bready  = 1'b0;
        rd_valid  = 1'b0;
        m_rready  = 1'b0;
        rd_data   = '0;
        rd_last   = 1'b0;
        unique case (state_q)
            // Not ready while reset is held, nor in the done-pulse cycle.
            S_IDLE:  req_ready = rst_n & ~done_valid_q;
            S_WADDR: m_awvalid = 1'b1;
            S_WDATA: begin
                m_wvalid = wr_valid;
                wr_ready = m_wready;
                m_wdata  = wr_data;
                m_wstrb  = wr_strb;
                m_wlast  = last_beat;
            end
            S_WRESP: m_bready  = 1'b1;
            S_RADDR: m_arvalid = 1'b1;
            S_RDATA: begin
                rd_valid = m_rvalid;
                m_rready = rd_ready;
                rd_data  = m_rdata;
                rd_last  = m_rlast;
            end
            default: ;
        endcase
    end

    assign m_awid      = id_q;
    assign m_awaddr    = addr_q;
    assign m_awlen     = len_q;
    assign m_awsize    = BEAT_SIZE;
    assign m_awburst   = 2'b01;
    assign m_arid      = id_q;
    assign m_araddr    = addr_q;
    assign m_arlen     = len_q;
    assign m_arsize    = BEAT_SIZE;
    assign m_arburst   = 2'b01;
    assign done_valid  = done_valid_q;
    assign done_write  = done_write_q;
    assign done_err    = done_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi_burst_master.sv
module tb_axi_burst_master;
  localparam int IW = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef AXI_BURST_MASTER_RCHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk, rst_n;
  logic req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [7:0] req_len;
  logic [IW-1:0] req_id;
  logic wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic done_valid, done_write, done_err;
  logic [IW-1:0] m_awid, m_arid, m_bid, m_rid;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [7:0] m_awlen, m_arlen;
  logic [2:0] m_awsize, m_arsize;
  logic [1:0] m_awburst, m_arburst;
  logic m_awvalid, m_awready, m_arvalid, m_arready;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_wstrb;
  logic m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_rlast, m_rvalid, m_rready;
  logic [2:0] dbg_state;

  axi_burst_master #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_id(req_id),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done_valid(done_valid), .done_write(done_write), .done_err(done_err),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- vectors and reference model ----------------
  typedef struct {
    bit          wr;
    logic [AW-1:0] addr;
    logic [7:0]  len;
    logic [IW-1:0] id;
    int          a_dly;     // address-ready delay, also B delay
    int          stall;     // 0 none, 1 fixed pattern, 2 random
    int          dmode;     // 0 random, 1 0xA5A5A5A5, 2 counting
    int          rlast_at;  // slave's rlast beat index (reads)
    int          bad_rid;   // beat index with wrong rid, -1 none
    int          exp_beats; // expected beats transferred
    bit          exp_err;   // expected done_err
  } vec_t;

  function automatic vec_t mk(bit wr, int addr, int len, int id, int a_dly, int stall,
                              int dmode, int rlast_at, int bad_rid, int beats, bit err);
    vec_t v;
    v.wr = wr; v.addr = AW'(addr); v.len = 8'(len); v.id = IW'(id);
    v.a_dly = a_dly; v.stall = stall; v.dmode = dmode;
    v.rlast_at = rlast_at; v.bad_rid = bad_rid;
    v.exp_beats = beats; v.exp_err = err;
    return v;
  endfunction

  // Expected outcome from the burst rules: writes always move len+1 beats;
  // reads stop at the slave's rlast, or (checked build) at len+1 beats
  // if that comes first, and flag an error on any disagreement.
  function automatic vec_t model(vec_t v);
    int n;
    if (v.wr) begin
      v.exp_beats = int'(v.len) + 1;
      v.exp_err = 1'b0;
    end else begin
      n = RC ? ((v.rlast_at < int'(v.len)) ? v.rlast_at : int'(v.len)) : v.rlast_at;
      v.exp_beats = n + 1;
      v.exp_err = RC && ((v.rlast_at != int'(v.len)) || (v.bad_rid >= 0 && v.bad_rid <= n));
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] gen_data(int dmode, int i);
    case (dmode)
      0: return DW'($urandom());
      1: return 32'hA5A5A5A5;
      default: return DW'(i);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    req_valid = 0; req_write = 0; req_addr = '0; req_len = '0; req_id = '0;
    wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
    m_awready = 0; m_wready = 0; m_bid = '0; m_bvalid = 0; m_arready = 0;
    m_rid = '0; m_rdata = '0; m_rlast = 0; m_rvalid = 0;
  endtask

  task automatic send_req(input vec_t v);
    @(negedge clk);
    req_valid = 1; req_write = v.wr; req_addr = v.addr; req_len = v.len; req_id = v.id;
    #1 check("req_ready_idle", req_ready, 1);
    @(posedge clk);
  endtask

  task automatic run_write(input vec_t v);
    logic [DW-1:0] dq[$];
    logic [SW-1:0] sq[$];
    int beat, cyc;
    exp_q.delete();
    for (int i = 0; i < v.exp_beats; i++) begin
      dq.push_back(gen_data(v.dmode, i));
      sq.push_back(v.dmode == 1 ? SW'(4'hF) : SW'($urandom_range(1, 15)));
      exp_q.push_back(dq[i]);
    end
    send_req(v);
    for (int k = 0; k <= v.a_dly; k++) begin
      @(negedge clk);
      req_valid = 0; m_awready = (k == v.a_dly); wr_valid = 1; wr_data = dq[0]; m_wready = 1;
      #1;
      check("awvalid", m_awvalid, 1);
      check("awaddr", m_awaddr, v.addr);
      check("awlen", m_awlen, v.len);
      check("awid", m_awid, v.id);
      check("awburst", m_awburst, 2'b01);
      check("awsize", m_awsize, 3'd2);
      check("aw_req_ready", req_ready, 0);
      check("w_before_aw", m_wvalid, 0);
      @(posedge clk);
    end
    beat = 0; cyc = 0;
    while (beat < v.exp_beats && cyc < 3000) begin
      @(negedge clk);
      m_awready = 0;
      case (v.stall)
        0: begin wr_valid = 1; m_wready = 1; end
        1: begin wr_valid = (cyc % 2 == 0); m_wready = 1; end
        default: begin wr_valid = 1'($urandom_range(0, 1)); m_wready = 1'($urandom_range(0, 1)); end
      endcase
      wr_data = dq[beat]; wr_strb = sq[beat];
      #1;
      check("wvalid_pass", m_wvalid, wr_valid);
      check("wready_pass", wr_ready, m_wready);
      if (wr_valid && m_wready) begin
        check("wdata", m_wdata, exp_q.pop_front());
        check("wstrb", m_wstrb, sq[beat]);
        check("wlast", m_wlast, beat == v.exp_beats - 1);
        beat++;
      end
      @(posedge clk);
      cyc++;
    end
    if (beat < v.exp_beats) check("w_timeout", 0, 1);
    for (int k = 0; k <= v.a_dly; k++) begin
      @(negedge clk);
      wr_valid = 1; m_wready = 1; m_bvalid = (k == v.a_dly); m_bid = IW'($urandom());
      #1;
      check("extra_wbeat", m_wvalid, 0);
      check("bready", m_bready, 1);
      check("early_done", done_valid, 0);
      @(posedge clk);
    end
    @(negedge clk);
    wr_valid = 0; m_wready = 0; m_bvalid = 0;
    #1;
    check("wdone_valid", done_valid, 1);
    check("wdone_write", done_write, 1);
    check("wdone_err", done_err, 0);
    check("wdone_req_ready", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("wdone_pulse_end", done_valid, 0);
    check("w_back_idle", req_ready, 1);
  endtask

  task automatic run_read(input vec_t v);
    logic [DW-1:0] dq[$];
    int sent, cyc;
    exp_q.delete();
    for (int i = 0; i < v.exp_beats; i++) begin
      dq.push_back(gen_data(v.dmode, i));
      exp_q.push_back(dq[i]);
    end
    send_req(v);
    for (int k = 0; k <= v.a_dly; k++) begin
      @(negedge clk);
      req_valid = 0; m_arready = (k == v.a_dly); m_rvalid = 1; rd_ready = 1;
      #1;
      check("arvalid", m_arvalid, 1);
      check("araddr", m_araddr, v.addr);
      check("arlen", m_arlen, v.len);
      check("arid", m_arid, v.id);
      check("arburst", m_arburst, 2'b01);
      check("arsize", m_arsize, 3'd2);
      check("ar_req_ready", req_ready, 0);
      check("r_before_ar", rd_valid | m_rready, 0);
      @(posedge clk);
    end
    sent = 0; cyc = 0;
    while (sent < v.exp_beats && cyc < 3000) begin
      @(negedge clk);
      m_arready = 0;
      case (v.stall)
        0: begin m_rvalid = 1; rd_ready = 1; end
        1: begin m_rvalid = 1; rd_ready = !(cyc == 2 || cyc == 3); end
        default: begin m_rvalid = 1'($urandom_range(0, 1)); rd_ready = 1'($urandom_range(0, 1)); end
      endcase
      m_rdata = dq[sent];
      m_rlast = (sent == v.rlast_at);
      m_rid = (sent == v.bad_rid) ? ~v.id : v.id;
      #1;
      check("rvalid_pass", rd_valid, m_rvalid);
      check("rready_pass", m_rready, rd_ready);
      if (m_rvalid && rd_ready) begin
        check("rdata", rd_data, exp_q.pop_front());
        check("rlast", rd_last, sent == v.rlast_at);
        sent++;
      end
      @(posedge clk);
      cyc++;
    end
    if (sent < v.exp_beats) check("r_timeout", 0, 1);
    @(negedge clk);
    m_rvalid = 1; rd_ready = 1; m_rlast = 0; m_rid = v.id;
    #1;
    check("extra_rbeat", rd_valid, 0);
    check("rdone_valid", done_valid, 1);
    check("rdone_write", done_write, 0);
    check("rdone_err", done_err, v.exp_err);
    check("rdone_req_ready", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    m_rvalid = 0; rd_ready = 0;
    #1;
    check("rdone_pulse_end", done_valid, 0);
    check("r_back_idle", req_ready, 1);
  endtask

  task automatic run_vec(input vec_t v);
    if (v.wr) run_write(v);
    else run_read(v);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_awvalid"}, m_awvalid, 0);
    check({tag, "_arvalid"}, m_arvalid, 0);
    check({tag, "_wvalid"}, m_wvalid, 0);
    check({tag, "_wlast"}, m_wlast, 0);
    check({tag, "_wr_ready"}, wr_ready, 0);
    check({tag, "_bready"}, m_bready, 0);
    check({tag, "_rready"}, m_rready, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_done"}, done_valid, 0);
    check({tag, "_awaddr"}, m_awaddr, 0);
    check({tag, "_awlen"}, m_awlen, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- test sequence ----------------
  vec_t vt[10];
  vec_t rv;

  initial begin
    vt[0] = mk(1, 'h10, 0, 1, 0, 0, 1, 0, -1, 1, 0);
    vt[1] = mk(1, 'h40, 3, 2, 0, 1, 0, 3, -1, 4, 0);
    vt[2] = mk(0, 'h20, 3, 3, 0, 1, 2, 3, -1, 4, 0);
    vt[3] = mk(1, 'h80, 2, 4, 5, 0, 0, 2, -1, 3, 0);
    vt[4] = mk(0, 'h90, 1, 5, 5, 0, 2, 1, -1, 2, 0);
    vt[5] = mk(0, 'h30, 3, 6, 0, 0, 2, 2, -1, 3, RC);
    vt[6] = mk(0, 'h34, 3, 7, 0, 0, 2, 3, 1, 4, RC);
    vt[7] = mk(0, 'h38, 1, 8, 0, 0, 2, 3, -1, RC ? 2 : 4, RC);
    vt[8] = mk(1, 'h100, 255, 9, 0, 0, 2, 255, -1, 256, 0);
    vt[9] = mk(0, 'h200, 255, 10, 1, 0, 2, 255, -1, 256, 0);

    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 check_quiet("reset");
    rst_n = 1;
    #1 check("req_ready_after_reset", req_ready, 1);

    foreach (vt[i]) run_vec(vt[i]);

    // reset asserted in the middle of a write data phase
    rv = mk(1, 'h80, 7, 5, 0, 0, 0, 7, -1, 8, 0);
    send_req(rv);
    @(negedge clk);
    req_valid = 0; m_awready = 1;
    @(posedge clk);
    @(negedge clk);
    m_awready = 0; wr_valid = 1; m_wready = 1; wr_data = 32'h1234_5678; wr_strb = 4'hF;
    #1 check("midw_wvalid", m_wvalid, 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1 check_quiet("midw_reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1; wr_valid = 0; m_wready = 0;
    run_read(mk(0, 'h20, 3, 3, 0, 0, 2, 3, -1, 4, 0));

    // randomized transactions against the model
    for (int n = 0; n < 16; n++) begin
      rv = mk($urandom_range(0, 1), $urandom_range(0, 16'hFFFF), $urandom_range(0, 7),
              $urandom_range(0, 15), $urandom_range(0, 3), 2, 0, 0, -1, 0, 0);
      rv.rlast_at = int'(rv.len);
      rv = model(rv);
      run_vec(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
